// File: rtl/atm_pkg.sv
// atm_pkg: key codes, controller mode encodings and frontend state enum
package atm_pkg;
  localparam logic [3:0] KEY_ENTER   = 4'd10;
  localparam logic [3:0] KEY_CANCEL  = 4'd11;
  localparam logic [3:0] KEY_WDRAW   = 4'd12;
  localparam logic [3:0] KEY_DEPOSIT = 4'd13;
  localparam logic [3:0] KEY_BAL     = 4'd14;
  localparam logic [3:0] KEY_PINCHG  = 4'd15;
  localparam logic [1:0] MODE_WDRAW   = 2'b00;
  localparam logic [1:0] MODE_DEPOSIT = 2'b01;
  localparam logic [1:0] MODE_BAL     = 2'b10;
  localparam logic [1:0] MODE_PINCHG  = 2'b11;
  typedef enum logic [2:0] {
    IDLE, PIN_ENTRY, MODE_SEL, AMT_ENTRY, NPIN_ENTRY, ISSUE, WAIT_RESP, REPORT
  } state_t;
  function automatic logic is_digit(input logic [3:0] k);
    return k < 4'd10;
  endfunction
endpackage

// File: rtl/atm_digit_accum.sv
// atm_digit_accum: decimal accumulator building a value from successive digit strobes
module atm_digit_accum #(
  parameter int DW = 17,
  parameter int MAX_DIGITS = 5,
  parameter int CW = $clog2(MAX_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          digit,
  input  logic [3:0]    d,
  output logic [DW-1:0] acc,
  output logic [CW-1:0] count,
  output logic          full
);
  assign full = count == CW'(MAX_DIGITS);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc   <= '0;
      count <= '0;
    end else if (digit) begin
      acc   <= acc * DW'(10) + DW'(d);
      count <= count + CW'(1);
    end
  end
endmodule

// File: rtl/atm_keypad_frontend.sv
// atm_keypad_frontend: turns keypad strobes and card-detect into ATM controller transactions
module atm_keypad_frontend
  import atm_pkg::*;
#(
  parameter int DW = 17,
  parameter int MAX_DIGITS = 5,
  parameter int TIMEOUT = 1024,
  parameter int HOLD = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          card_in,
  input  logic          key_valid,
  input  logic [3:0]    key_code,
  input  logic          ctrl_sucess,
  input  logic          ctrl_error,
  input  logic [DW-1:0] ctrl_balance,
  output logic          ctrl_card,
  output logic [DW-1:0] ctrl_pin,
  output logic [DW-1:0] ctrl_new_pin,
  output logic [1:0]    ctrl_modes,
  output logic [DW-1:0] ctrl_money,
  output logic          ctrl_valid,
  output logic [DW-1:0] disp_balance,
  output logic          done,
  output logic          fail,
  output logic          timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(HOLD + 1);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  state_t state, nxt;
  logic [TW-1:0] timer;
  logic [HW-1:0] hold;
  logic [DW-1:0] acc;
  logic [CW-1:0] count;
  logic full, entry, cancel, latch, mode_key, suc, err, tmo, resp, hold_end, acc_clr, acc_dig;
  atm_digit_accum #(.DW(DW), .MAX_DIGITS(MAX_DIGITS), .CW(CW)) u_acc (
    .clk(clk), .rst(rst), .clr(acc_clr), .digit(acc_dig), .d(key_code),
    .acc(acc), .count(count), .full(full)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:                  nxt = PIN_ENTRY;
      PIN_ENTRY:             nxt = latch ? MODE_SEL : state;
      MODE_SEL:              nxt = !mode_key ? state : key_code == KEY_BAL ? ISSUE :
                                   key_code == KEY_PINCHG ? NPIN_ENTRY : AMT_ENTRY;
      AMT_ENTRY, NPIN_ENTRY: nxt = latch ? ISSUE : state;
      ISSUE:                 nxt = WAIT_RESP;
      WAIT_RESP:             nxt = resp ? REPORT : state;
      REPORT:                nxt = hold_end ? MODE_SEL : state;
      default:               nxt = IDLE;
    endcase
    if (!card_in || cancel) nxt = IDLE;
  end
  always_comb begin
    entry    = state inside {PIN_ENTRY, AMT_ENTRY, NPIN_ENTRY};
    cancel   = key_valid && key_code == KEY_CANCEL && !(state inside {IDLE, WAIT_RESP});
    latch    = entry && key_valid && key_code == KEY_ENTER && count != '0;
    mode_key = state == MODE_SEL && key_valid && key_code >= KEY_WDRAW && key_code != KEY_CANCEL;
    err      = state == WAIT_RESP && ctrl_error;
    suc      = state == WAIT_RESP && ctrl_sucess && !ctrl_error;
    tmo      = state == WAIT_RESP && !ctrl_error && !ctrl_sucess && timer == TW'(TIMEOUT - 1);
    resp     = err || suc || tmo;
    hold_end = state == REPORT && hold == HW'(HOLD - 1);
    acc_clr  = !card_in || cancel || latch;
    acc_dig  = entry && key_valid && is_digit(key_code) && !full;
  end
  always_ff @(posedge clk) ctrl_card <= !rst && card_in;
  always_ff @(posedge clk) begin
    if (rst || !card_in) begin
      {ctrl_pin, ctrl_new_pin, ctrl_money, ctrl_modes, ctrl_valid} <= '0;
      {disp_balance, done, fail, timeout, timer, hold} <= '0;
    end else if (cancel) begin
      {ctrl_pin, ctrl_new_pin, ctrl_money, ctrl_modes} <= '0;
      {done, fail, timeout} <= '0;
    end else begin
      if (latch && state == PIN_ENTRY) ctrl_pin <= acc;
      if (latch && state == AMT_ENTRY) ctrl_money <= acc;
      if (latch && state == NPIN_ENTRY) ctrl_new_pin <= acc;
      if (mode_key) ctrl_modes <= key_code[1:0];
      if (state == ISSUE) begin
        ctrl_valid <= 1'b1;
        timer      <= '0;
      end
      if (state == WAIT_RESP) begin
        timer <= timer + TW'(1);
        if (resp) begin
          ctrl_valid <= 1'b0;
          done       <= suc;
          fail       <= err || tmo;
          timeout    <= tmo;
          hold       <= '0;
          if (suc) disp_balance <= ctrl_balance;
        end
      end
      if (state == REPORT) begin
        hold <= hold + HW'(1);
        if (hold_end) begin
          {done, fail, timeout} <= '0;
          ctrl_money   <= '0;
          ctrl_new_pin <= '0;
          if (done && ctrl_modes == MODE_PINCHG) ctrl_pin <= ctrl_new_pin;
        end
      end
    end
  end
endmodule

// File: tb/tb_atm_keypad_frontend.sv
// tb_atm_keypad_frontend: scenario and randomized transaction checks for the keypad frontend
module tb_atm_keypad_frontend;
  localparam int DW = 17, HOLD = 16, TIMEOUT = 1024, MAXD = 5;
  localparam logic [3:0] ENT = 10, CAN = 11, WD = 12, DEP = 13, BAL = 14, PCH = 15;
  logic clk = 0, rst = 1, card_in = 0, key_valid = 0, ctrl_sucess = 0, ctrl_error = 0;
  logic [3:0] key_code = 0;
  logic [DW-1:0] ctrl_balance = 0;
  logic ctrl_card, ctrl_valid, done, fail, timeout;
  logic [DW-1:0] ctrl_pin, ctrl_new_pin, ctrl_money, disp_balance;
  logic [1:0] ctrl_modes;
  int n_tests = 0, n_fail = 0;
  int digs[$];
  int exp_pin = 0, exp_disp = 0;
  always #5 clk = ~clk;
  atm_keypad_frontend dut (
    .clk(clk), .rst(rst), .card_in(card_in), .key_valid(key_valid), .key_code(key_code),
    .ctrl_sucess(ctrl_sucess), .ctrl_error(ctrl_error), .ctrl_balance(ctrl_balance),
    .ctrl_card(ctrl_card), .ctrl_pin(ctrl_pin), .ctrl_new_pin(ctrl_new_pin),
    .ctrl_modes(ctrl_modes), .ctrl_money(ctrl_money), .ctrl_valid(ctrl_valid),
    .disp_balance(disp_balance), .done(done), .fail(fail), .timeout(timeout)
  );
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic press(input logic [3:0] k);
    key_valid = 1; key_code = k;
    @(negedge clk);
    key_valid = 0; key_code = 0;
  endtask
  task automatic type_digs();
    foreach (digs[i]) press(4'(digs[i]));
  endtask
  function automatic int fold();
    int v = 0;
    for (int i = 0; i < digs.size() && i < MAXD; i++) v = v * 10 + digs[i];
    return v;
  endfunction
  task automatic set_digs(input int v);
    digs.delete();
    if (v == 0) digs.push_back(0);
    while (v > 0) begin
      digs.push_front(v % 10);
      v = v / 10;
    end
  endtask
  task automatic rand_digs(input int lo, input int hi);
    digs.delete();
    repeat ($urandom_range(hi, lo)) digs.push_back($urandom_range(9, 0));
  endtask
  task automatic respond(input bit s, input bit e, input int bal);
    ctrl_sucess = s; ctrl_error = e; ctrl_balance = DW'(bal);
    @(negedge clk);
    ctrl_sucess = 0; ctrl_error = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({ctrl_card, ctrl_pin, ctrl_new_pin, ctrl_modes, ctrl_money, ctrl_valid, disp_balance, done, fail, timeout} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got pin=%0d valid=%0d card=%0d, expected all 0", ctrl_pin, ctrl_valid, ctrl_card);
    end
    card_in = 1;
    @(negedge clk);
    n_tests++;
    if (ctrl_card !== 1'b0) begin
      n_fail++; $display("FAIL reset_card: got ctrl_card=%0d expected 0", ctrl_card);
    end
    rst = 0; card_in = 0;
    @(negedge clk);
  endtask
  task automatic test_withdraw_success();
    int c = 0;
    card_in = 1;
    @(negedge clk);
    n_tests++;
    if (ctrl_card !== 1'b1) begin
      n_fail++; $display("FAIL card_follow: got %0d expected 1", ctrl_card);
    end
    set_digs(1211); type_digs(); press(ENT); exp_pin = 1211;
    n_tests++;
    if (ctrl_pin !== DW'(1211)) begin
      n_fail++; $display("FAIL wd_pin: got %0d expected 1211", ctrl_pin);
    end
    press(WD); set_digs(100); type_digs(); press(ENT);
    @(negedge clk);
    n_tests++;
    if ({ctrl_valid, ctrl_modes, ctrl_money, ctrl_new_pin} !== {1'b1, 2'b00, DW'(100), DW'(0)}) begin
      n_fail++; $display("FAIL wd_issue: got valid=%0d modes=%0d money=%0d new_pin=%0d expected 1 0 100 0", ctrl_valid, ctrl_modes, ctrl_money, ctrl_new_pin);
    end
    respond(1, 0, 900); exp_disp = 900;
    n_tests++;
    if ({done, fail, timeout, ctrl_valid, disp_balance} !== {4'b1000, DW'(900)}) begin
      n_fail++; $display("FAIL wd_report: got done=%0d fail=%0d tmo=%0d valid=%0d bal=%0d expected 1 0 0 0 900", done, fail, timeout, ctrl_valid, disp_balance);
    end
    while (done && c < HOLD + 4) begin
      c++;
      @(negedge clk);
    end
    n_tests++;
    if (c !== HOLD) begin
      n_fail++; $display("FAIL wd_hold: got %0d cycles expected %0d", c, HOLD);
    end
    n_tests++;
    if ({ctrl_pin, ctrl_money} !== {DW'(1211), DW'(0)}) begin
      n_fail++; $display("FAIL wd_after: got pin=%0d money=%0d expected 1211 0", ctrl_pin, ctrl_money);
    end
  endtask
  task automatic test_deposit_error();
    press(DEP); set_digs(200); type_digs(); press(ENT);
    @(negedge clk);
    n_tests++;
    if ({ctrl_valid, ctrl_modes, ctrl_money} !== {1'b1, 2'b01, DW'(200)}) begin
      n_fail++; $display("FAIL dep_issue: got valid=%0d modes=%0d money=%0d expected 1 1 200", ctrl_valid, ctrl_modes, ctrl_money);
    end
    respond(0, 1, 555);
    n_tests++;
    if ({done, fail, timeout, disp_balance} !== {3'b010, DW'(exp_disp)}) begin
      n_fail++; $display("FAIL dep_report: got done=%0d fail=%0d tmo=%0d bal=%0d expected 0 1 0 %0d", done, fail, timeout, disp_balance, exp_disp);
    end
    repeat (HOLD) @(negedge clk);
    n_tests++;
    if ({done, fail, timeout} !== 3'b000) begin
      n_fail++; $display("FAIL dep_clear: got %b expected 000", {done, fail, timeout});
    end
  endtask
  task automatic test_balance_timeout();
    int c = 0;
    press(BAL);
    @(negedge clk);
    n_tests++;
    if ({ctrl_valid, ctrl_modes, ctrl_money} !== {1'b1, 2'b10, DW'(0)}) begin
      n_fail++; $display("FAIL bal_issue: got valid=%0d modes=%0d money=%0d expected 1 2 0", ctrl_valid, ctrl_modes, ctrl_money);
    end
    while (!fail && c < TIMEOUT + 8) begin
      @(negedge clk);
      c++;
    end
    n_tests++;
    if (c !== TIMEOUT) begin
      n_fail++; $display("FAIL tmo_cycles: got %0d expected %0d", c, TIMEOUT);
    end
    n_tests++;
    if ({fail, timeout, done, ctrl_valid} !== 4'b1100) begin
      n_fail++; $display("FAIL tmo_flags: got %b expected 1100", {fail, timeout, done, ctrl_valid});
    end
    repeat (HOLD) @(negedge clk);
  endtask
  task automatic test_pin_change();
    int b = $urandom_range(131071, 0);
    press(PCH); set_digs(1234); type_digs(); press(ENT);
    @(negedge clk);
    n_tests++;
    if ({ctrl_valid, ctrl_modes, ctrl_new_pin, ctrl_money, ctrl_pin} !== {1'b1, 2'b11, DW'(1234), DW'(0), DW'(exp_pin)}) begin
      n_fail++; $display("FAIL pch_issue: got modes=%0d new_pin=%0d money=%0d pin=%0d expected 3 1234 0 %0d", ctrl_modes, ctrl_new_pin, ctrl_money, ctrl_pin, exp_pin);
    end
    respond(1, 0, b); exp_disp = b;
    n_tests++;
    if ({done, disp_balance, ctrl_pin} !== {1'b1, DW'(b), DW'(exp_pin)}) begin
      n_fail++; $display("FAIL pch_report: got done=%0d bal=%0d pin=%0d expected 1 %0d %0d", done, disp_balance, ctrl_pin, b, exp_pin);
    end
    repeat (HOLD) @(negedge clk);
    exp_pin = 1234;
    n_tests++;
    if ({ctrl_pin, ctrl_new_pin} !== {DW'(1234), DW'(0)}) begin
      n_fail++; $display("FAIL pch_after: got pin=%0d new_pin=%0d expected 1234 0", ctrl_pin, ctrl_new_pin);
    end
  endtask
  task automatic test_digit_limit_cancel();
    press(CAN);
    n_tests++;
    if ({ctrl_pin, ctrl_modes} !== '0) begin
      n_fail++; $display("FAIL cancel_mode: got pin=%0d modes=%0d expected 0 0", ctrl_pin, ctrl_modes);
    end
    @(negedge clk);
    press(ENT); press(BAL);
    digs = '{1, 2, 3, 4, 5, 6, 7};
    type_digs(); press(ENT); exp_pin = fold();
    n_tests++;
    if (ctrl_pin !== DW'(exp_pin)) begin
      n_fail++; $display("FAIL digit_limit: got %0d expected %0d", ctrl_pin, exp_pin);
    end
    press(CAN); exp_pin = 0;
    n_tests++;
    if (ctrl_pin !== '0) begin
      n_fail++; $display("FAIL cancel_pin: got %0d expected 0", ctrl_pin);
    end
    @(negedge clk);
  endtask
  task automatic test_card_pull();
    set_digs(4321); type_digs(); press(ENT);
    press(WD); set_digs(50); type_digs(); press(ENT);
    @(negedge clk);
    n_tests++;
    if ({ctrl_valid, ctrl_money} !== {1'b1, DW'(50)}) begin
      n_fail++; $display("FAIL pull_issue: got valid=%0d money=%0d expected 1 50", ctrl_valid, ctrl_money);
    end
    card_in = 0; ctrl_sucess = 1; ctrl_balance = 777;
    @(negedge clk);
    ctrl_sucess = 0; exp_disp = 0;
    n_tests++;
    if ({ctrl_card, ctrl_pin, ctrl_new_pin, ctrl_modes, ctrl_money, ctrl_valid, disp_balance, done, fail, timeout} !== '0) begin
      n_fail++; $display("FAIL pull_clear: got done=%0d valid=%0d pin=%0d bal=%0d expected all 0", done, ctrl_valid, ctrl_pin, disp_balance);
    end
    @(negedge clk);
    n_tests++;
    if ({done, fail, ctrl_valid} !== 3'b000) begin
      n_fail++; $display("FAIL pull_stay: got %b expected 000", {done, fail, ctrl_valid});
    end
  endtask
  task automatic test_rst_mid();
    card_in = 1;
    @(negedge clk);
    set_digs(98); type_digs(); press(ENT); press(BAL);
    @(negedge clk);
    n_tests++;
    if (ctrl_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_issue: got valid=%0d expected 1", ctrl_valid);
    end
    rst = 1; ctrl_sucess = 1;
    @(negedge clk);
    rst = 0; ctrl_sucess = 0;
    n_tests++;
    if ({ctrl_card, ctrl_pin, ctrl_modes, ctrl_valid, disp_balance, done, fail, timeout} !== '0) begin
      n_fail++; $display("FAIL rst_mid_clear: got done=%0d valid=%0d pin=%0d expected all 0", done, ctrl_valid, ctrl_pin);
    end
    @(negedge clk);
    n_tests++;
    if ({ctrl_card, done} !== 2'b10) begin
      n_fail++; $display("FAIL rst_mid_after: got card=%0d done=%0d expected 1 0", ctrl_card, done);
    end
  endtask
  task automatic test_random_txns();
    logic [3:0] k;
    int money, np, r, bal;
    for (int it = 0; it < 12; it++) begin
      card_in = 0;
      @(negedge clk);
      card_in = 1; exp_disp = 0;
      @(negedge clk);
      rand_digs(1, 7); type_digs(); press(ENT); exp_pin = fold();
      n_tests++;
      if (ctrl_pin !== DW'(exp_pin)) begin
        n_fail++; $display("FAIL rand_pin: got %0d expected %0d", ctrl_pin, exp_pin);
      end
      repeat (2) begin
        k = 4'($urandom_range(15, 12)); money = 0; np = 0;
        press(k);
        if (k != BAL) begin
          rand_digs(1, 7); type_digs(); press(ENT);
          if (k == PCH) np = fold(); else money = fold();
        end
        @(negedge clk);
        n_tests++;
        if ({ctrl_valid, ctrl_modes, ctrl_money, ctrl_new_pin, ctrl_pin} !== {1'b1, 2'(k - 12), DW'(money), DW'(np), DW'(exp_pin)}) begin
          n_fail++; $display("FAIL rand_issue: got modes=%0d money=%0d new_pin=%0d pin=%0d expected %0d %0d %0d %0d", ctrl_modes, ctrl_money, ctrl_new_pin, ctrl_pin, k - 12, money, np, exp_pin);
        end
        r = $urandom_range(2, 0); bal = $urandom_range(131071, 0);
        respond(r != 1, r != 0, bal);
        if (r == 0) exp_disp = bal;
        n_tests++;
        if ({done, fail, timeout, disp_balance} !== {r == 0, r != 0, 1'b0, DW'(exp_disp)}) begin
          n_fail++; $display("FAIL rand_report: got done=%0d fail=%0d tmo=%0d bal=%0d expected %0d %0d 0 %0d", done, fail, timeout, disp_balance, r == 0, r != 0, exp_disp);
        end
        repeat (HOLD) @(negedge clk);
        if (r == 0 && k == PCH) exp_pin = np;
        n_tests++;
        if ({ctrl_pin, ctrl_money, ctrl_new_pin, done, fail} !== {DW'(exp_pin), DW'(0), DW'(0), 2'b00}) begin
          n_fail++; $display("FAIL rand_after: got pin=%0d money=%0d new_pin=%0d expected %0d 0 0", ctrl_pin, ctrl_money, ctrl_new_pin, exp_pin);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_withdraw_success();
    test_deposit_error();
    test_balance_timeout();
    test_pin_change();
    test_digit_limit_cancel();
    test_card_pull();
    test_rst_mid();
    test_random_txns();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
